// File: rtl/afu_rd_pkg.sv
// Shared types and helpers for the AFU read-request sequencer.
package afu_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_SWITCH = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int MAX_REGIONS = 16;
  localparam int RIDX_W      = 4;
  localparam int REGION_LSB  = 0;

  // Returns {found, idx}: first available region after cur. With wrap=1 the
  // search is round-robin and may land on cur itself as the last candidate.
  function automatic logic [RIDX_W:0] next_region(
    input logic                   wrap,
    input logic [RIDX_W-1:0]      cur,
    input logic [MAX_REGIONS-1:0] avail,
    input int                     num
  );
    logic [RIDX_W:0] res;
    int              cand;
    res = '0;
    for (int i = 1; i <= MAX_REGIONS; i++) begin
      cand = int'(cur) + i;
      if (wrap && cand >= num) cand = cand - num;
      if (!res[RIDX_W] && i <= num && cand < num && avail[cand[RIDX_W-1:0]]) begin
        res = {1'b1, cand[RIDX_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rd_credit_counter.sv
// Up/down in-flight counter with a ceiling flag and an underflow strobe.
module rd_credit_counter #(
  parameter int MAX = 64,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o,
  output logic         underflow_o
);

  logic [W-1:0] count_q, count_d;

  assign count_o     = count_q;
  assign at_max_o    = (count_q >= W'(MAX));
  assign underflow_o = dec_i & (count_q == '0);

  // A decrement at zero is reported but never wraps the count.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/afu_rd_req_sequencer.sv
// Streams cacheline read requests from several regions, sequential or
// chunk-interleaved, honouring per-region stall, QPI back-pressure and a credit cap.
module afu_rd_req_sequencer
  import afu_rd_pkg::*;
#(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int NUM_REGIONS     = 4,
  parameter int REGION_W        = 2,
  parameter int MAX_OUTSTANDING = 64,
  parameter int LEN_W           = 16,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [NUM_REGIONS*ADDR_LMT-1:0] cfg_base,
  input  logic [NUM_REGIONS*LEN_W-1:0]    cfg_len,
  input  logic [LEN_W-1:0]                cfg_chunk,
  input  logic [NUM_REGIONS-1:0]          region_stall,
  output logic [ADDR_LMT-1:0]             rd_req_addr,
  output logic [MDATA-1:0]                rd_req_mdata,
  output logic                            rd_req_en,
  input  logic                            rd_req_almostfull,
  input  logic                            rd_rsp_valid,
  input  logic [MDATA-1:0]                rd_rsp_mdata,
  output logic [OUT_W-1:0]                outstanding,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [2:0]                      dbg_state
);

  localparam int SEQ_W   = MDATA - REGION_W;
  localparam int SEQ_LSB = REGION_LSB + REGION_W;

  state_e                state_q, state_d;
  logic                  mode_q;
  logic [LEN_W-1:0]      chunk_q, chunk_cnt_q;
  logic [ADDR_LMT-1:0]   base_q [NUM_REGIONS];
  logic [LEN_W-1:0]      len_q  [NUM_REGIONS];
  logic [LEN_W-1:0]      rem_q  [NUM_REGIONS];
  logic [LEN_W-1:0]      off_q  [NUM_REGIONS];
  logic [REGION_W-1:0]   cur_q, cur_d;
  logic [SEQ_W-1:0]      seq_q;
  logic                  err_q;
  logic [NUM_REGIONS-1:0] len_nz, rem_nz;
  logic [RIDX_W:0]       first_sel, next_sel;
  logic                  accept_start, issue, at_max, underflow, last_in_region, chunk_hit;
  logic                  unused_rsp_tag;

  assign unused_rsp_tag = ^rd_rsp_mdata;

  always_comb begin
    for (int r = 0; r < NUM_REGIONS; r++) begin
      len_nz[r] = (len_q[r] != '0);
      rem_nz[r] = (rem_q[r] != '0);
    end
  end

  assign first_sel = next_region(1'b1, RIDX_W'(NUM_REGIONS - 1), MAX_REGIONS'(len_nz), NUM_REGIONS);
  assign next_sel  = next_region(mode_q, RIDX_W'(cur_q), MAX_REGIONS'(rem_nz), NUM_REGIONS);

  assign accept_start = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  // rd_req_en is a one-cycle strobe: each asserted cycle is one accepted request.
  // It is only raised when the QPI port and the region's buffer can both take it.
  assign issue = (state_q == S_ISSUE) & ~rd_req_almostfull & ~region_stall[cur_q]
               & ~at_max & rem_nz[cur_q];
  assign last_in_region = (rem_q[cur_q] == LEN_W'(1));
  assign chunk_hit      = mode_q & ((chunk_cnt_q + LEN_W'(1)) == chunk_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (first_sel[RIDX_W]) begin
          state_d = S_ISSUE;
          cur_d   = REGION_W'(first_sel[RIDX_W-1:0]);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_ISSUE: if (issue && (last_in_region || chunk_hit)) state_d = S_SWITCH;
      S_SWITCH: begin
        if (next_sel[RIDX_W]) begin
          state_d = S_ISSUE;
          cur_d   = REGION_W'(next_sel[RIDX_W-1:0]);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (outstanding == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_req_en    = issue;
  assign rd_req_addr  = issue ? base_q[cur_q] + ADDR_LMT'(off_q[cur_q]) : '0;
  assign rd_req_mdata = issue ? {seq_q, cur_q} : '0;
  assign busy         = (state_q == S_LOAD) | (state_q == S_ISSUE)
                      | (state_q == S_SWITCH) | (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      seq_q       <= '0;
      chunk_cnt_q <= '0;
      chunk_q     <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        base_q[r] <= '0;
        len_q[r]  <= '0;
        rem_q[r]  <= '0;
        off_q[r]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (accept_start) begin
        mode_q  <= mode;
        chunk_q <= (cfg_chunk == '0) ? LEN_W'(1) : cfg_chunk;
        for (int r = 0; r < NUM_REGIONS; r++) begin
          base_q[r] <= cfg_base[r*ADDR_LMT +: ADDR_LMT];
          len_q[r]  <= cfg_len[r*LEN_W +: LEN_W];
        end
      end
      if (state_q == S_LOAD) begin
        seq_q       <= '0;
        chunk_cnt_q <= '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
          rem_q[r] <= len_q[r];
          off_q[r] <= '0;
        end
      end
      if (issue) begin
        rem_q[cur_q] <= rem_q[cur_q] - LEN_W'(1);
        off_q[cur_q] <= off_q[cur_q] + LEN_W'(1);
        seq_q        <= seq_q + SEQ_W'(1);
        chunk_cnt_q  <= chunk_cnt_q + LEN_W'(1);
      end
      if (state_q == S_SWITCH) chunk_cnt_q <= '0;
      // A stray response in the same cycle as start still leaves err set.
      if (accept_start) err_q <= 1'b0;
      if (underflow)    err_q <= 1'b1;
    end
  end

  rd_credit_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (OUT_W)
  ) u_credit (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .inc_i       (issue),
    .dec_i       (rd_rsp_valid),
    .count_o     (outstanding),
    .at_max_o    (at_max),
    .underflow_o (underflow)
  );

endmodule

// File: tb/tb_afu_rd_req_sequencer.sv
// Self-checking bench for afu_rd_req_sequencer with a request scoreboard and a response model.
module tb_afu_rd_req_sequencer;

  localparam int ADDR_LMT = 20;
  localparam int MDATA    = 14;
  localparam int NR       = 4;
  localparam int LEN_W    = 16;
  localparam int MAXO     = 4;
  localparam int OUT_W    = 3;
  localparam int EW       = ADDR_LMT + MDATA;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic                   mode;
  logic [NR*ADDR_LMT-1:0] cfg_base;
  logic [NR*LEN_W-1:0]    cfg_len;
  logic [LEN_W-1:0]       cfg_chunk;
  logic [NR-1:0]          region_stall;
  logic [ADDR_LMT-1:0]    rd_req_addr;
  logic [MDATA-1:0]       rd_req_mdata;
  logic                   rd_req_en;
  logic                   rd_req_almostfull;
  logic                   rd_rsp_valid;
  logic [MDATA-1:0]       rd_rsp_mdata;
  logic [OUT_W-1:0]       outstanding;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [2:0]             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int n_issued = 0;
  int n_rsp    = 0;
  int manual_cnt = 0;
  bit auto_rsp   = 1'b1;

  logic [EW-1:0]    exp_q[$];
  int               exp_cyc_q[$];
  logic [MDATA-1:0] pend_q[$];
  int               pend_t_q[$];
  logic [EW-1:0]    mon_e;
  int               mon_ec;

  afu_rd_req_sequencer #(
    .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .NUM_REGIONS(NR), .REGION_W(2),
    .MAX_OUTSTANDING(MAXO), .LEN_W(LEN_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_chunk(cfg_chunk),
    .region_stall(region_stall), .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .outstanding(outstanding), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rd_req_en === 1'b1) begin
      n_issued++;
      pend_q.push_back(rd_req_mdata);
      pend_t_q.push_back(cyc + 2);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: got addr=%h mdata=%h, required no request", rd_req_addr, rd_req_mdata);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        if ({rd_req_addr, rd_req_mdata} !== mon_e) begin
          n_fail++;
          $display("FAIL req_value: got addr=%h mdata=%h, required addr=%h mdata=%h",
                   rd_req_addr, rd_req_mdata, mon_e[EW-1:MDATA], mon_e[MDATA-1:0]);
        end
        if (mon_ec >= 0) begin
          n_tests++;
          if (cyc - t0 != mon_ec) begin
            n_fail++;
            $display("FAIL req_cycle: got cycle %0d, required %0d (addr=%h)", cyc - t0, mon_ec, rd_req_addr);
          end
        end
      end
    end
  end

  // ---------------- response model ----------------
  initial begin
    rd_rsp_valid = 1'b0;
    rd_rsp_mdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_rsp_valid = 1'b0;
      if (manual_cnt > 0) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
        if (pend_t_q.size() > 0) void'(pend_t_q.pop_front());
        manual_cnt--;
        n_rsp++;
      end else if (auto_rsp && pend_q.size() > 0 && pend_t_q[0] <= cyc) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = pend_q.pop_front();
        void'(pend_t_q.pop_front());
        n_rsp++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_regions();
    cfg_base = '0;
    cfg_len  = '0;
  endtask

  task automatic set_region(input int r, input logic [ADDR_LMT-1:0] b, input logic [LEN_W-1:0] l);
    cfg_base[r*ADDR_LMT +: ADDR_LMT] = b;
    cfg_len[r*LEN_W +: LEN_W]        = l;
  endtask

  task automatic push_exp(input logic [ADDR_LMT-1:0] a, input int seq, input int r, input int c);
    logic [MDATA-1:0] md;
    md = {seq[MDATA-3:0], r[1:0]};
    exp_q.push_back({a, md});
    exp_cyc_q.push_back(c);
  endtask

  task automatic start_pass();
    @(posedge clk);
    #1;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int took);
    took = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1 && took < 0) took = i;
      if (took >= 0) break;
    end
  endtask

  task automatic wait_issued(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_issued >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; cfg_chunk = '0;
    region_stall = '0; rd_req_almostfull = 1'b0;
    clear_regions();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (rd_req_en !== 1'b0)  begin n_fail++; $display("FAIL reset_en: got %b, required 0", rd_req_en); end
    n_tests++; if (rd_req_addr !== '0)  begin n_fail++; $display("FAIL reset_addr: got %h, required 0", rd_req_addr); end
    n_tests++; if (outstanding !== '0)  begin n_fail++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
    n_tests++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/err=%b, required 000", {busy, done, err}); end
    n_tests++; if (dbg_state !== 3'd0)  begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    int took;
    int rsp0;
    clear_regions();
    set_region(0, 20'h00100, 16'd3);
    set_region(1, 20'h00800, 16'd2);
    mode = 1'b0; cfg_chunk = '0; auto_rsp = 1'b1;
    push_exp(20'h00100, 0, 0, 2);
    push_exp(20'h00101, 1, 0, 3);
    push_exp(20'h00102, 2, 0, 4);
    push_exp(20'h00800, 3, 1, 6);
    push_exp(20'h00801, 4, 1, 7);
    rsp0 = n_rsp;
    start_pass();
    wait_done(60, took);
    n_tests++; if (took < 0) begin n_fail++; $display("FAIL seq_done: got timeout, required done"); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_missing: got %0d pending, required 0", exp_q.size()); end
    n_tests++; if (n_rsp - rsp0 != 5) begin n_fail++; $display("FAIL seq_rsp_at_done: got %0d responses, required 5", n_rsp - rsp0); end
    n_tests++; if ({busy, outstanding} !== 4'b0000) begin n_fail++; $display("FAIL seq_idle: got busy=%b outstanding=%0d, required 0/0", busy, outstanding); end
  endtask

  task automatic test_interleave();
    int took;
    clear_regions();
    set_region(0, 20'h00200, 16'd3);
    set_region(1, 20'h00300, 16'd3);
    mode = 1'b1; cfg_chunk = 16'd2;
    push_exp(20'h00200, 0, 0, 2);
    push_exp(20'h00201, 1, 0, 3);
    push_exp(20'h00300, 2, 1, 5);
    push_exp(20'h00301, 3, 1, 6);
    push_exp(20'h00202, 4, 0, 8);
    push_exp(20'h00302, 5, 1, 10);
    start_pass();
    wait_done(60, took);
    n_tests++; if (took < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL ilv_chunk2: got took=%0d pending=%0d, required done/0", took, exp_q.size()); end
    // chunk 0 behaves as 1; the last live region is re-selected by itself
    clear_regions();
    set_region(0, 20'h00400, 16'd1);
    set_region(1, 20'h00500, 16'd3);
    cfg_chunk = 16'd0;
    push_exp(20'h00400, 0, 0, 2);
    push_exp(20'h00500, 1, 1, 4);
    push_exp(20'h00501, 2, 1, 6);
    push_exp(20'h00502, 3, 1, 8);
    start_pass();
    wait_done(60, took);
    n_tests++; if (took < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL ilv_chunk0: got took=%0d pending=%0d, required done/0", took, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int took;
    int base;
    bit ok;
    clear_regions();
    set_region(0, 20'h01000, 16'd12);
    mode = 1'b0; cfg_chunk = '0;
    for (int i = 0; i < 12; i++) push_exp(20'h01000 + 20'(i), i, 0, -1);
    base = n_issued;
    start_pass();
    wait_issued(base + 3, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_first_issues: got %0d, required 3", n_issued - base); end
    @(posedge clk); #1 rd_req_almostfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (rd_req_en !== 1'b0) begin n_fail++; $display("FAIL bp_almostfull: got en=%b, required 0", rd_req_en); end
    end
    @(posedge clk); #1 rd_req_almostfull = 1'b0;
    @(posedge clk); #1 region_stall = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (rd_req_en !== 1'b0) begin n_fail++; $display("FAIL bp_region_stall: got en=%b, required 0", rd_req_en); end
    end
    @(posedge clk); #1 region_stall = '0;
    wait_done(100, took);
    n_tests++; if (took < 0 || exp_q.size() != 0 || n_issued - base != 12) begin
      n_fail++; $display("FAIL bp_complete: got took=%0d pending=%0d issued=%0d, required done/0/12", took, exp_q.size(), n_issued - base);
    end
  endtask

  task automatic test_credit();
    int took;
    int base;
    int both_k;
    logic en_a [5];
    logic rsp_a [5];
    logic [OUT_W-1:0] out_a [5];
    clear_regions();
    set_region(0, 20'h02000, 16'd10);
    mode = 1'b0; cfg_chunk = '0; auto_rsp = 1'b0;
    for (int i = 0; i < 10; i++) push_exp(20'h02000 + 20'(i), i, 0, (i < 4) ? i + 2 : -1);
    base = n_issued;
    start_pass();
    repeat (10) @(negedge clk);
    n_tests++; if (n_issued - base != 4) begin n_fail++; $display("FAIL credit_cap: got %0d issues, required 4", n_issued - base); end
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL credit_cap_count: got %0d, required 4", outstanding); end
    manual_cnt = 1;
    repeat (5) @(negedge clk);
    n_tests++; if (n_issued - base != 5 || outstanding !== 3'd4) begin
      n_fail++; $display("FAIL credit_single: got issues=%0d outstanding=%0d, required 5/4", n_issued - base, outstanding);
    end
    manual_cnt = 2;
    both_k = -1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en_a[k] = rd_req_en; rsp_a[k] = rd_rsp_valid; out_a[k] = outstanding;
      if (both_k < 0 && en_a[k] === 1'b1 && rsp_a[k] === 1'b1) both_k = k;
    end
    n_tests++;
    if (both_k < 0 || both_k > 3) begin
      n_fail++; $display("FAIL credit_overlap: got no issue+response cycle, required one");
    end else begin
      n_tests++;
      if (out_a[both_k+1] !== out_a[both_k]) begin
        n_fail++; $display("FAIL credit_overlap_hold: got %0d after, required %0d", out_a[both_k+1], out_a[both_k]);
      end
    end
    n_tests++; if (n_issued - base != 7 || outstanding !== 3'd4) begin
      n_fail++; $display("FAIL credit_double: got issues=%0d outstanding=%0d, required 7/4", n_issued - base, outstanding);
    end
    auto_rsp = 1'b1;
    wait_done(200, took);
    n_tests++; if (took < 0 || exp_q.size() != 0 || n_issued - base != 10) begin
      n_fail++; $display("FAIL credit_complete: got took=%0d pending=%0d issued=%0d, required done/0/10", took, exp_q.size(), n_issued - base);
    end
  endtask

  task automatic test_zero_wrap();
    int took;
    int base;
    clear_regions();
    mode = 1'b0; cfg_chunk = '0;
    base = n_issued;
    start_pass();
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_cycle2: got done=%b busy=%b, required 0/1", done, busy); end
    @(negedge clk);
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_cycle3: got done=%b busy=%b, required 1/0", done, busy); end
    n_tests++; if (n_issued != base) begin n_fail++; $display("FAIL zero_no_req: got %0d issues, required 0", n_issued - base); end
    set_region(0, 20'hFFFFE, 16'd3);
    push_exp(20'hFFFFE, 0, 0, 2);
    push_exp(20'hFFFFF, 1, 0, 3);
    push_exp(20'h00000, 2, 0, 4);
    start_pass();
    wait_done(60, took);
    n_tests++; if (took < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_done: got took=%0d pending=%0d, required done/0", took, exp_q.size()); end
  endtask

  task automatic test_reset_err();
    int base;
    bit ok;
    clear_regions();
    set_region(0, 20'h03000, 16'd20);
    mode = 1'b0; auto_rsp = 1'b1;
    for (int i = 0; i < 20; i++) push_exp(20'h03000 + 20'(i), i, 0, -1);
    base = n_issued;
    start_pass();
    wait_issued(base + 3, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_pre_issue: got %0d issues, required 3", n_issued - base); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    auto_rsp = 1'b0;
    pend_q.delete(); pend_t_q.delete();
    #1;
    n_tests++; if ({rd_req_en, busy, done, err} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_flags: got en/busy/done/err=%b, required 0000", {rd_req_en, busy, done, err});
    end
    n_tests++; if (rd_req_addr !== '0 || rd_req_mdata !== '0 || outstanding !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: got addr=%h mdata=%h out=%0d, required 0/0/0", rd_req_addr, rd_req_mdata, outstanding);
    end
    exp_q.delete(); exp_cyc_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after: got err=%b busy=%b, required 0/0", err, busy); end
    manual_cnt = 1;
    repeat (2) @(negedge clk);
    n_tests++; if (err !== 1'b1 || outstanding !== '0) begin n_fail++; $display("FAIL err_set: got err=%b out=%0d, required 1/0", err, outstanding); end
    repeat (3) @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", err); end
    clear_regions();
    start_pass();
    @(negedge clk);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b, required 0", err); end
    repeat (2) @(negedge clk);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_pass_done: got %b, required 1", done); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_interleave();
    test_backpressure();
    test_credit();
    test_zero_wrap();
    test_reset_err();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
